// File: rtl/main_fsm_pkg.sv
// Shared types and constants for the multicycle RISC-V controller main FSM.
// Optional memory handshake is enabled with MAIN_FSM_MEM_READY_EN.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        JAL      = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10,
        HALT     = 4'd11
    } statetype;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       adr_src;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Moore output decoder: maps the state register to the datapath control word.
// Unused encodings and HALT produce an all-zero word.
module main_fsm_outdec
    import main_fsm_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.ir_write   = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.pc_update  = 1'b1;
            end
            DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMREAD: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
            end
            MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
            end
            EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V controller main FSM: state register, sequencing, sticky illegal flag.
// Define MAIN_FSM_MEM_READY_EN to add a mem_ready handshake on FETCH/MEMREAD/MEMWRITE.
module main_fsm
    import main_fsm_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
`ifdef MAIN_FSM_MEM_READY_EN
    input  logic       mem_ready,
`endif
    input  logic [6:0] op,
    output logic       pc_update,
    output logic       branch,
    output logic       reg_write,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       adr_src,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic [3:0] state_o
);

    logic [3:0] state;
    logic [3:0] state_next;
    logic       ready;
    ctrl_t      ctrl;

`ifdef MAIN_FSM_MEM_READY_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal <= 1'b0;
        end else if ((state == DECODE) && !is_supported(op)) begin
            illegal <= 1'b1;
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = ready ? DECODE : FETCH;
            DECODE: begin
                if ((op == OP_LW) || (op == OP_SW)) state_next = MEMADR;
                else if (op == OP_R)                state_next = EXECR;
                else if (op == OP_I)                state_next = EXECI;
                else if (op == OP_BEQ)              state_next = BEQ;
                else if (op == OP_JAL)              state_next = JAL;
                else                                state_next = ILLEGAL_TRAP ? HALT : FETCH;
            end
            MEMADR:   state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = ready ? MEMWB : MEMREAD;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = ready ? FETCH : MEMWRITE;
            EXECR:    state_next = ALUWB;
            EXECI:    state_next = ALUWB;
            JAL:      state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BEQ:      state_next = FETCH;
            HALT:     state_next = HALT;
            default:  state_next = FETCH;
        endcase
    end

    main_fsm_outdec u_outdec (
        .state (state),
        .ctrl  (ctrl)
    );

    // Enables are gated by the reset level so they drop in the cycle reset asserts.
    logic fetch_gate;
    assign fetch_gate = (state == FETCH) ? ready : 1'b1;

    assign pc_update  = ctrl.pc_update & reset & fetch_gate;
    assign ir_write   = ctrl.ir_write  & reset & fetch_gate;
    assign branch     = ctrl.branch    & reset;
    assign reg_write  = ctrl.reg_write & reset;
    assign mem_write  = ctrl.mem_write & reset;
    assign result_src = ctrl.result_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign adr_src    = ctrl.adr_src;
    assign alu_op     = ctrl.alu_op;
    assign state_o    = state;

endmodule
